prog_uart_rx: RTL and testbench
===============================

PROG_UART_RX -- requirements
Module: prog_uart_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1085 (125 MHz / 115200 baud), meaning clock cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port rx_i  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-005 SHALL have port rd_en_i  input  1  pop request for the receive buffer.
REQ-006 SHALL have port rd_data_o  output  32  {24'h0, byte} when buffer valid, else 32'hFFFF_FFFF.
REQ-007 SHALL have port busy_o  output  1  high while a frame is being received (state != IDLE).
REQ-008 SHALL have port frame_err_o  output  1  one-cycle pulse on bad stop bit.
REQ-009 SHALL have port overrun_o  output  1  one-cycle pulse when a valid unread byte is overwritten.

Function
REQ-010 SHALL pass rx_i through a 2-flop synchronizer, then one edge-history flop; start detection uses only synchronized values.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-012 IDLE: on synchronized high-to-low transition, SHALL load 16-bit bit counter with CLK_DIV>>1, go to START; a line held low from reset SHALL NOT trigger.
REQ-013 Bit counter SHALL decrement every cycle outside IDLE; a "sample tick" occurs in the cycle the counter equals 0, and it then reloads with CLK_DIV-1.
REQ-014 START: at sample tick, line low -> DATA with bit index 0; line high -> IDLE (false start, no outputs change).
REQ-015 DATA: at each sample tick, SHALL shift the sampled bit into the shift register MSB (LSB-first assembly); after bit index 7, go to STOP; 3-bit index wraps to 0.
REQ-016 STOP: at sample tick, line high -> write byte to buffer, set valid, go to IDLE; line low -> discard byte, pulse frame_err_o, go to IDLE.
REQ-017 Byte SHALL be visible on rd_data_o in the cycle after the stop-bit sample tick.
REQ-018 rd_data_o SHALL be combinational from buffer and valid flag only (no dependence on rd_en_i).
REQ-019 rd_en_i with valid set SHALL clear valid at the next edge; rd_en_i with valid clear SHALL have no effect.
REQ-020 Buffer write while valid set and no pop in the same cycle: new byte overwrites, valid stays 1, overrun_o pulses one cycle.
REQ-021 Buffer write and pop in the same cycle: new byte wins, valid stays 1, no overrun pulse.
REQ-022 Receiver SHALL be ready for the next start edge in the cycle after the stop sample (half-stop-bit tolerance for back-to-back frames).
REQ-023 rd_en_i SHALL be accepted continuously (level), so a consumer holding it high pops every byte one cycle after it appears.

Reset
REQ-024 On rst_ni low, asynchronously: FSM=IDLE, counter=0, bit index=0, shift register=0, buffer=0, valid=0, synchronizer and edge flops=1.
REQ-025 Output values in reset: rd_data_o=32'hFFFF_FFFF, busy_o=0, frame_err_o=0, overrun_o=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no buffer write or error pulse; after release, the next falling edge starts a fresh frame.

Verification (CLK_DIV=8)
REQ-027 Reset released, rx_i high 100 cycles -> rd_data_o=32'hFFFF_FFFF, busy_o=0, no pulses.
REQ-028 Send 0x54, rd_en_i low -> rd_data_o=32'h0000_0054 from cycle after stop sample, held; one-cycle rd_en_i -> 32'hFFFF_FFFF next cycle.
REQ-029 rx_i low for 2 cycles then high -> busy_o returns 0 after half bit, no byte, no frame_err_o.
REQ-030 Send 0xA5 with stop bit 0 -> frame_err_o pulses exactly one cycle, rd_data_o remains 32'hFFFF_FFFF.
REQ-031 Send 0x11 then 0x22 back-to-back without reading -> overrun_o pulses once, rd_data_o=32'h0000_0022; repeat with rd_en_i held high -> no overrun, both bytes observed.
REQ-032 Assert rst_ni during DATA of 0x3C, release, send 0x4B -> only 32'h0000_004B ever appears.

Source files
------------

// File: rtl/prog_uart_rx.sv
// prog_uart_rx: 8N1 UART receiver with a programmable bit period and a
// single-entry receive buffer.
//
// Read handshake: rd_data_o is valid whenever it is not 32'hFFFF_FFFF.
// rd_en_i is a level-sensitive pop. When the buffer holds a byte, a high
// rd_en_i clears the buffer at the next clock edge. When the buffer is
// empty, rd_en_i has no effect. A byte written in the same cycle as a pop
// replaces the popped byte and does not raise overrun_o.
module prog_uart_rx #(
  parameter int unsigned CLK_DIV = 1085
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_i,
  input  logic        rd_en_i,
  output logic [31:0] rd_data_o,
  output logic        busy_o,
  output logic        frame_err_o,
  output logic        overrun_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // The first sample lands half a bit after the falling edge. Every later
  // sample lands one full bit period after the previous sample.
  localparam logic [15:0] HALF_BIT   = 16'(CLK_DIV >> 1);
  localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  buf_q, buf_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        sync1_q, sync2_q, hist_q;
  logic        tick;
  logic        wr_en;

  // Two-flop synchronizer plus one history flop used for edge detection.
  // These flops reset to the idle-high level, so a line held low from
  // reset is never seen as a falling edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      buf_q       <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      buf_q       <= buf_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic: frame sequencing, bit timing and buffer update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    buf_d       = buf_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    wr_en       = 1'b0;
    tick        = (cnt_q == 16'd0);

    if (state_q != IDLE) begin
      cnt_d = tick ? BIT_RELOAD : cnt_q - 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (hist_q && !sync2_q) begin
          cnt_d   = HALF_BIT;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (!sync2_q) begin
            state_d = DATA;
            idx_d   = 3'd0;
          end else begin
            // False start: the line was a glitch, so return quietly.
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          // Bits arrive LSB first. Each new bit enters at the MSB, so after
          // eight samples the first bit has moved down to bit 0.
          shift_d = {sync2_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          if (sync2_q) begin
            wr_en = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rd_en_i && valid_q) begin
      valid_d = 1'b0;
    end
    if (wr_en) begin
      buf_d     = shift_q;
      valid_d   = 1'b1;
      overrun_d = valid_q && !rd_en_i;
    end
  end

  assign rd_data_o   = valid_q ? {24'h0, buf_q} : 32'hFFFF_FFFF;
  assign busy_o      = (state_q != IDLE);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_prog_uart_rx.sv
// tb_prog_uart_rx: drives 8N1 frames into prog_uart_rx at CLK_DIV=8. A
// frame-level model predicts the bytes, error pulses and overrun pulses
// that the receiver must produce.
module tb_prog_uart_rx;

  localparam int CLK_DIV = 8;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        busy;
  logic        frame_err;
  logic        overrun;

  int n_checks;
  int n_fail;

  // Monitor state.
  int         fe_events, fe_cycles, ov_events, ov_cycles;
  logic       fe_prev, ov_prev;
  bit         busy_seen;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];

  prog_uart_rx #(.CLK_DIV(CLK_DIV)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rx_i       (rx),
    .rd_en_i    (rd_en),
    .rd_data_o  (rd_data),
    .busy_o     (busy),
    .frame_err_o(frame_err),
    .overrun_o  (overrun)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample the outputs on the falling edge. This process records pulse
  // counts and widths, and every byte that a pop consumes.
  always @(negedge clk) begin
    if (!rst_n) begin
      fe_prev = 1'b0;
      ov_prev = 1'b0;
    end else begin
      if (frame_err) fe_cycles++;
      if (frame_err && !fe_prev) fe_events++;
      if (overrun) ov_cycles++;
      if (overrun && !ov_prev) ov_events++;
      fe_prev = frame_err;
      ov_prev = overrun;
      if (busy) busy_seen = 1'b1;
      if (rd_en && rd_data !== 32'hFFFF_FFFF) obs_q.push_back(rd_data[7:0]);
    end
  end

  task automatic clear_mon();
    fe_events = 0;
    fe_cycles = 0;
    ov_events = 0;
    ov_cycles = 0;
    busy_seen = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  // Advance n rising edges, then step just past the edge so that inputs
  // never race the DUT flops.
  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One complete 8N1 frame. Every bit lasts CLK_DIV cycles.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    tick_n(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick_n(CLK_DIV);
    end
    rx = stop_ok;
    tick_n(CLK_DIV);
  endtask

  task automatic compare_queues(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) check({tag, "_byte"}, {24'h0, obs_q[i]}, {24'h0, exp_q[i]});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rx       = 1'b1;
    rd_en    = 1'b0;
    clear_mon();

    // Reset state, then an idle line.
    tick_n(3);
    @(negedge clk);
    check("rst_rd_data", rd_data, 32'hFFFF_FFFF);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_pulses", {30'h0, frame_err, overrun}, 32'h0);
    rst_n = 1'b1;
    tick_n(1);
    clear_mon();
    tick_n(100);
    @(negedge clk);
    check("idle_rd_data", rd_data, 32'hFFFF_FFFF);
    check("idle_busy", {31'h0, busy}, 32'h0);
    check("idle_busy_seen", {31'h0, busy_seen}, 32'h0);
    check("idle_pulses", fe_events + ov_events, 32'h0);

    // Receive 0x54 with no read: hold the byte, then pop it once.
    tick_n(1);
    clear_mon();
    send_frame(8'h54, 1'b1);
    @(negedge clk);
    check("byte_visible", rd_data, 32'h0000_0054);
    tick_n(20);
    @(negedge clk);
    check("byte_held", rd_data, 32'h0000_0054);
    tick_n(1);
    rd_en = 1'b1;
    tick_n(1);
    rd_en = 1'b0;
    @(negedge clk);
    check("byte_popped", rd_data, 32'hFFFF_FFFF);
    check("byte_no_err", fe_events + ov_events, 32'h0);

    // False start: a two-cycle low glitch.
    tick_n(1);
    clear_mon();
    rx = 1'b0;
    tick_n(2);
    rx = 1'b1;
    tick_n(20);
    @(negedge clk);
    check("false_busy_seen", {31'h0, busy_seen}, 32'h1);
    check("false_busy", {31'h0, busy}, 32'h0);
    check("false_rd_data", rd_data, 32'hFFFF_FFFF);
    check("false_no_fe", fe_events, 32'h0);

    // Bad stop bit.
    tick_n(1);
    clear_mon();
    send_frame(8'hA5, 1'b0);
    rx = 1'b1;
    tick_n(10);
    @(negedge clk);
    check("ferr_events", fe_events, 32'd1);
    check("ferr_width", fe_cycles, 32'd1);
    check("ferr_rd_data", rd_data, 32'hFFFF_FFFF);
    check("ferr_no_ov", ov_events, 32'h0);

    // Two back-to-back bytes with no read cause an overrun.
    tick_n(1);
    clear_mon();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick_n(4);
    @(negedge clk);
    check("ovr_events", ov_events, 32'd1);
    check("ovr_width", ov_cycles, 32'd1);
    check("ovr_rd_data", rd_data, 32'h0000_0022);
    tick_n(1);
    rd_en = 1'b1;
    tick_n(2);

    // The same two bytes with rd_en held high.
    clear_mon();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick_n(4);
    @(negedge clk);
    compare_queues("stream");
    check("stream_no_ov", ov_events, 32'h0);

    // Reset arrives during the data bits of 0x3C.
    tick_n(1);
    clear_mon();
    rx = 1'b0;
    tick_n(CLK_DIV);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(8'h3C >> i);
      tick_n(CLK_DIV);
    end
    rst_n = 1'b0;
    rx    = 1'b1;
    tick_n(3);
    @(negedge clk);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_rd_data", rd_data, 32'hFFFF_FFFF);
    tick_n(1);
    rst_n = 1'b1;
    tick_n(3);
    exp_q.push_back(8'h4B);
    send_frame(8'h4B, 1'b1);
    tick_n(4);
    @(negedge clk);
    compare_queues("midrst");
    check("midrst_no_fe", fe_events, 32'h0);

    // Random frames with occasional bad stop bits and random gaps.
    tick_n(1);
    clear_mon();
    begin
      int exp_fe;
      exp_fe = 0;
      for (int f = 0; f < 24; f++) begin
        logic [7:0] b;
        bit         ok;
        b  = 8'($urandom_range(0, 255));
        ok = ($urandom_range(0, 4) != 0);
        send_frame(b, ok);
        if (ok) begin
          exp_q.push_back(b);
          tick_n($urandom_range(0, 3));
        end else begin
          exp_fe++;
          rx = 1'b1;
          tick_n($urandom_range(2, 5));
        end
      end
      tick_n(4);
      @(negedge clk);
      compare_queues("rand");
      check("rand_fe", fe_events, exp_fe);
      check("rand_fe_width", fe_cycles, exp_fe);
      check("rand_no_ov", ov_events, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
